scoreboard: RTL and testbench
=============================

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, giving the width of each per-register in-flight writer counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports iss0_valid/iss1_valid  input  1  slot0/slot1 instruction issued this cycle.
REQ-005 SHALL have ports iss0_rd/iss1_rd  input  5  destination register of the issuing instruction.
REQ-006 SHALL have ports iss0_reg_write/iss1_reg_write  input  1  the issuing instruction writes rd.
REQ-007 SHALL have ports iss0_is_load/iss1_is_load  input  1  the issuing instruction is a load.
REQ-008 SHALL have ports wb0_valid/wb1_valid  input  1  a register write retires this cycle.
REQ-009 SHALL have ports wb0_rd/wb1_rd  input  5  register being written back.
REQ-010 SHALL have port ld_done_valid  input  1  load data has returned from memory and is forwardable.
REQ-011 SHALL have port ld_done_rd  input  5  destination of the returned load.
REQ-012 SHALL have port clear_all  input  1  synchronous pipeline restart; empties the scoreboard.
REQ-013 SHALL have port busy_vec  output  32  bit r set while register r has at least one in-flight writer.
REQ-014 SHALL have port load_pending_vec  output  32  bit r set while an in-flight load to r has not returned data.
REQ-015 SHALL have port sb_err  output  1  sticky flag for counter overflow or underflow.

Function
REQ-016 SHALL hold one CNT_W-bit counter cnt[r] and one lp[r] bit for each r in 1..31; register 0 SHALL never be tracked.
REQ-017 An issue event to r SHALL occur when issN_valid, issN_reg_write and issN_rd==r with r!=0.
REQ-018 A writeback event to r SHALL occur when wbN_valid and wbN_rd==r with r!=0.
REQ-019 Per cycle, next cnt[r] SHALL be cnt[r] + (issue events to r, 0..2) - (writeback events to r, 0..2), computed at CNT_W+2 bits signed.
REQ-020 If that result exceeds 2^CNT_W-1, cnt[r] SHALL saturate at max and sb_err SHALL set.
REQ-021 If that result is below 0, cnt[r] SHALL clamp to 0 and sb_err SHALL set.
REQ-022 Issue and writeback to the same r in the same cycle SHALL net out: count unchanged, no error.
REQ-023 busy_vec[r] SHALL be (cnt[r]!=0) taken from registered state; busy_vec[0] SHALL be 0.
REQ-024 There SHALL be no combinational bypass from the iss or wb inputs to the outputs; events SHALL become visible one cycle after they are presented.
REQ-025 lp[r] SHALL set on an issue event with issN_is_load to r.
REQ-026 lp[r] SHALL clear on ld_done_valid with ld_done_rd==r.
REQ-027 When lp[r] sees a set and a clear in the same cycle, set SHALL win, because the issuing load is younger.
REQ-028 lp[r] SHALL also clear whenever next cnt[r]==0.
REQ-029 load_pending_vec SHALL equal lp & busy_vec; load_pending_vec[0] SHALL be 0.
REQ-030 A load issue event to r!=0 with iss_reg_write=0 SHALL be ignored.
REQ-031 ld_done_valid for an r with lp[r]=0 SHALL be ignored, with no error.
REQ-032 When both slots load to the same r in the same cycle, cnt[r] SHALL gain 2 and lp[r] SHALL set once.
REQ-033 clear_all SHALL zero all cnt and lp on the next edge and take priority over every simultaneous event.
REQ-034 clear_all SHALL NOT clear sb_err.
REQ-035 sb_err SHALL remain set until reset.

Reset
REQ-036 While rst_n=0, all cnt, lp, busy_vec, load_pending_vec and sb_err SHALL be 0 immediately, without waiting for a clock edge.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight tracking.
REQ-038 The first edge after rst_n deasserts SHALL process inputs normally.

Verification
REQ-039 Issue ALU slot0 rd=5, then wb rd=5 two cycles later -> busy_vec[5]=1 for exactly 2 cycles, then 0; load_pending_vec=0 throughout.
REQ-040 Issue slot0 load rd=7, then ld_done rd=7 next cycle, then wb rd=7 the cycle after -> load_pending_vec[7]=1 for 1 cycle; busy_vec[7]=1 for 2 cycles.
REQ-041 Issue slot0 rd=3 and slot1 rd=3 together, then wb0 rd=3 -> cnt[3] goes 2 then 1, busy_vec[3] stays 1; a second wb clears it.
REQ-042 Same-cycle slot0 issue rd=9 and wb0 rd=9 with cnt[9]=1 -> busy_vec[9] stays 1, sb_err=0; wb rd=9 with cnt[9]=0 -> sb_err=1 and stays 1.
REQ-043 Issue rd=0 on both slots with load and wb rd=0 -> busy_vec=0, load_pending_vec=0, sb_err=0.
REQ-044 With 4 registers busy, assert clear_all together with a new issue rd=2 -> all vectors 0 next cycle; then pull rst_n low asynchronously mid-cycle -> sb_err=0 immediately.

Source files
------------

// File: rtl/scoreboard_if.sv
// Issue, writeback and load-return signals into the scoreboard, plus its status outputs.
interface scoreboard_if;
  logic        iss0_valid;
  logic        iss1_valid;
  logic [4:0]  iss0_rd;
  logic [4:0]  iss1_rd;
  logic        iss0_reg_write;
  logic        iss1_reg_write;
  logic        iss0_is_load;
  logic        iss1_is_load;
  logic        wb0_valid;
  logic        wb1_valid;
  logic [4:0]  wb0_rd;
  logic [4:0]  wb1_rd;
  logic        ld_done_valid;
  logic [4:0]  ld_done_rd;
  logic        clear_all;
  logic [31:0] busy_vec;
  logic [31:0] load_pending_vec;
  logic        sb_err;

  modport master (
    output iss0_valid, iss1_valid, iss0_rd, iss1_rd, iss0_reg_write, iss1_reg_write,
           iss0_is_load, iss1_is_load, wb0_valid, wb1_valid, wb0_rd, wb1_rd,
           ld_done_valid, ld_done_rd, clear_all,
    input  busy_vec, load_pending_vec, sb_err
  );

  modport slave (
    input  iss0_valid, iss1_valid, iss0_rd, iss1_rd, iss0_reg_write, iss1_reg_write,
           iss0_is_load, iss1_is_load, wb0_valid, wb1_valid, wb0_rd, wb1_rd,
           ld_done_valid, ld_done_rd, clear_all,
    output busy_vec, load_pending_vec, sb_err
  );
endinterface

// File: rtl/scoreboard.sv
// Dual-issue register scoreboard: per-register in-flight writer counts and pending-load bits.
module scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input logic         clk,
  input logic         rst_n,
  scoreboard_if.slave sb
);

  localparam int unsigned SumW = CNT_W + 2;
  typedef logic signed [SumW-1:0] sum_t;
  localparam sum_t CntMax = sum_t'((2 ** CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q [1:31];
  logic [CNT_W-1:0] cnt_d [1:31];
  logic [31:0]      lp_q, lp_d;
  logic             err_q, err_d;
  logic [31:1]      iss0_hit, iss1_hit, wb0_hit, wb1_hit, ld_hit, load_set;
  logic [31:0]      busy;

  always_comb begin
    for (int r = 1; r < 32; r++) begin
      iss0_hit[r] = sb.iss0_valid && sb.iss0_reg_write && (sb.iss0_rd == 5'(r));
      iss1_hit[r] = sb.iss1_valid && sb.iss1_reg_write && (sb.iss1_rd == 5'(r));
      wb0_hit[r]  = sb.wb0_valid && (sb.wb0_rd == 5'(r));
      wb1_hit[r]  = sb.wb1_valid && (sb.wb1_rd == 5'(r));
      ld_hit[r]   = sb.ld_done_valid && (sb.ld_done_rd == 5'(r));
      load_set[r] = (iss0_hit[r] && sb.iss0_is_load) || (iss1_hit[r] && sb.iss1_is_load);
    end
  end

  always_comb begin
    sum_t sum;
    sum   = '0;
    err_d = err_q;
    lp_d  = '0;
    for (int r = 1; r < 32; r++) begin
      sum = sum_t'({2'b00, cnt_q[r]}) + sum_t'(iss0_hit[r]) + sum_t'(iss1_hit[r])
            - sum_t'(wb0_hit[r]) - sum_t'(wb1_hit[r]);
      if (sum[SumW-1]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (sum > CntMax) begin
        cnt_d[r] = '1;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = sum[CNT_W-1:0];
      end
      // A load issuing now is younger than any returning load, so set beats clear.
      if (load_set[r])    lp_d[r] = 1'b1;
      else if (ld_hit[r]) lp_d[r] = 1'b0;
      else                lp_d[r] = lp_q[r];
      if (cnt_d[r] == '0) lp_d[r] = 1'b0;
    end
    // Restart drops every simultaneous event, including any error it would raise.
    if (sb.clear_all) begin
      for (int r = 1; r < 32; r++) cnt_d[r] = '0;
      lp_d  = '0;
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
      lp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lp_q  <= lp_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = |cnt_q[r];
    sb.busy_vec         = busy;
    sb.load_pending_vec = lp_q & busy;
    sb.sb_err           = err_q;
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed vector table, hand-written corner sequences and randomized model comparison.
module tb_scoreboard;
  localparam int CntW   = 2;
  localparam int CntMax = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scoreboard_if sbi ();
  scoreboard #(.CNT_W(CntW)) dut (.clk(clk), .rst_n(rst_n), .sb(sbi));

  int checks   = 0;
  int failures = 0;

  int m_cnt [32];
  bit m_lp  [32];
  bit m_err;

  // Issue field {valid, reg_write, is_load, rd}; event field {valid, rd}.
  typedef struct {
    logic [7:0]  i0;
    logic [7:0]  i1;
    logic [5:0]  w0;
    logic [5:0]  w1;
    logic [5:0]  ld;
    logic        clr;
    logic [31:0] busy;
    logic [31:0] lp;
    logic        err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] alu(input int r);
    logic [31:0] v = r;
    return {3'b110, v[4:0]};
  endfunction
  function automatic logic [7:0] ldi(input int r);
    logic [31:0] v = r;
    return {3'b111, v[4:0]};
  endfunction
  function automatic logic [7:0] ldnw(input int r);
    logic [31:0] v = r;
    return {3'b101, v[4:0]};
  endfunction
  function automatic logic [5:0] ev(input int r);
    logic [31:0] v = r;
    return {1'b1, v[4:0]};
  endfunction
  function automatic logic [31:0] bm(input int r);
    return 32'd1 << r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    sbi.iss0_valid = 0; sbi.iss0_reg_write = 0; sbi.iss0_is_load = 0; sbi.iss0_rd = '0;
    sbi.iss1_valid = 0; sbi.iss1_reg_write = 0; sbi.iss1_is_load = 0; sbi.iss1_rd = '0;
    sbi.wb0_valid = 0; sbi.wb0_rd = '0; sbi.wb1_valid = 0; sbi.wb1_rd = '0;
    sbi.ld_done_valid = 0; sbi.ld_done_rd = '0; sbi.clear_all = 0;
  endtask

  task automatic apply(input vec_t v);
    {sbi.iss0_valid, sbi.iss0_reg_write, sbi.iss0_is_load, sbi.iss0_rd} = v.i0;
    {sbi.iss1_valid, sbi.iss1_reg_write, sbi.iss1_is_load, sbi.iss1_rd} = v.i1;
    {sbi.wb0_valid, sbi.wb0_rd} = v.w0;
    {sbi.wb1_valid, sbi.wb1_rd} = v.w1;
    {sbi.ld_done_valid, sbi.ld_done_rd} = v.ld;
    sbi.clear_all = v.clr;
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      m_lp[r]  = 0;
    end
    m_err = 0;
  endfunction

  function automatic void model_step();
    if (sbi.clear_all) begin
      for (int r = 0; r < 32; r++) begin
        m_cnt[r] = 0;
        m_lp[r]  = 0;
      end
      return;
    end
    for (int r = 1; r < 32; r++) begin
      bit e0 = sbi.iss0_valid && sbi.iss0_reg_write && (sbi.iss0_rd == r);
      bit e1 = sbi.iss1_valid && sbi.iss1_reg_write && (sbi.iss1_rd == r);
      bit b0 = sbi.wb0_valid && (sbi.wb0_rd == r);
      bit b1 = sbi.wb1_valid && (sbi.wb1_rd == r);
      int n  = m_cnt[r] + int'(e0) + int'(e1) - int'(b0) - int'(b1);
      if (n > CntMax) begin n = CntMax; m_err = 1; end
      if (n < 0) begin n = 0; m_err = 1; end
      m_cnt[r] = n;
      if ((e0 && sbi.iss0_is_load) || (e1 && sbi.iss1_is_load)) m_lp[r] = 1;
      else if (sbi.ld_done_valid && sbi.ld_done_rd == r)        m_lp[r] = 0;
      if (n == 0) m_lp[r] = 0;
    end
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic logic [31:0] model_lp();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = m_lp[r] && (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " busy"}, sbi.busy_vec, model_busy());
    check({tag, " lp"}, sbi.load_pending_vec, model_lp());
    check({tag, " err"}, {31'b0, sbi.sb_err}, {31'b0, m_err});
  endtask

  task automatic check_out(input string tag, input logic [31:0] b, input logic [31:0] l,
                           input logic e);
    check({tag, " busy"}, sbi.busy_vec, b);
    check({tag, " lp"}, sbi.load_pending_vec, l);
    check({tag, " err"}, {31'b0, sbi.sb_err}, {31'b0, e});
  endtask

  initial begin
    tbl.push_back('{ldi(0), ldi(0), ev(0), ev(0), ev(0), 1'b0, '0, '0, 1'b0, "r0_ignored"});
    tbl.push_back('{alu(5), '0, '0, '0, '0, 1'b0, bm(5), '0, 1'b0, "alu_iss"});
    tbl.push_back('{'0, '0, '0, '0, '0, 1'b0, bm(5), '0, 1'b0, "alu_hold"});
    tbl.push_back('{'0, '0, ev(5), '0, '0, 1'b0, '0, '0, 1'b0, "alu_wb"});
    tbl.push_back('{ldnw(12), '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, "ld_no_rw"});
    tbl.push_back('{ldi(7), '0, '0, '0, '0, 1'b0, bm(7), bm(7), 1'b0, "ld_iss"});
    tbl.push_back('{'0, '0, '0, '0, ev(7), 1'b0, bm(7), '0, 1'b0, "ld_done"});
    tbl.push_back('{'0, '0, ev(7), '0, '0, 1'b0, '0, '0, 1'b0, "ld_wb"});
    tbl.push_back('{'0, '0, '0, '0, ev(13), 1'b0, '0, '0, 1'b0, "ld_done_stray"});
    tbl.push_back('{alu(3), alu(3), '0, '0, '0, 1'b0, bm(3), '0, 1'b0, "dual_iss"});
    tbl.push_back('{'0, '0, ev(3), '0, '0, 1'b0, bm(3), '0, 1'b0, "dual_wb0"});
    tbl.push_back('{'0, '0, '0, ev(3), '0, 1'b0, '0, '0, 1'b0, "dual_wb1"});
    tbl.push_back('{ldi(15), ldi(15), '0, '0, '0, 1'b0, bm(15), bm(15), 1'b0, "dual_ld"});
    tbl.push_back('{'0, '0, ev(15), '0, '0, 1'b0, bm(15), bm(15), 1'b0, "dual_ld_wb0"});
    tbl.push_back('{'0, '0, ev(15), '0, '0, 1'b0, '0, '0, 1'b0, "dual_ld_wb1"});
    tbl.push_back('{ldi(14), '0, '0, '0, '0, 1'b0, bm(14), bm(14), 1'b0, "sw_iss"});
    tbl.push_back('{'0, ldi(14), '0, '0, ev(14), 1'b0, bm(14), bm(14), 1'b0, "set_wins"});
    tbl.push_back('{'0, '0, ev(14), ev(14), '0, 1'b0, '0, '0, 1'b0, "sw_wb2"});
    tbl.push_back('{ldi(16), '0, '0, '0, '0, 1'b0, bm(16), bm(16), 1'b0, "lp_iss"});
    tbl.push_back('{'0, '0, ev(16), '0, '0, 1'b0, '0, '0, 1'b0, "lp_cnt0"});
    tbl.push_back('{alu(16), '0, '0, '0, '0, 1'b0, bm(16), '0, 1'b0, "lp_stale"});
    tbl.push_back('{'0, '0, ev(16), '0, '0, 1'b0, '0, '0, 1'b0, "lp_stale_wb"});
    tbl.push_back('{alu(9), '0, '0, '0, '0, 1'b0, bm(9), '0, 1'b0, "net_pre"});
    tbl.push_back('{alu(9), '0, ev(9), '0, '0, 1'b0, bm(9), '0, 1'b0, "net_out"});
    tbl.push_back('{'0, '0, ev(9), '0, '0, 1'b0, '0, '0, 1'b0, "net_wb"});
    tbl.push_back('{'0, '0, ev(9), '0, '0, 1'b0, '0, '0, 1'b1, "underflow"});
    tbl.push_back('{'0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b1, "err_sticky"});

    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #12;
    check_out("reset", '0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      tick();
      check_out(tbl[i].name, tbl[i].busy, tbl[i].lp, tbl[i].err);
    end

    // Four busy registers, then clear_all alongside a new issue; sb_err survives it.
    @(negedge clk); drive_idle();
    sbi.iss0_valid = 1; sbi.iss0_reg_write = 1; sbi.iss0_rd = 5'd4;
    sbi.iss1_valid = 1; sbi.iss1_reg_write = 1; sbi.iss1_rd = 5'd6;
    tick();
    @(negedge clk); sbi.iss0_rd = 5'd8; sbi.iss1_rd = 5'd10;
    tick();
    check_out("four_busy", bm(4) | bm(6) | bm(8) | bm(10), '0, 1'b1);
    @(negedge clk); drive_idle();
    sbi.clear_all = 1; sbi.iss0_valid = 1; sbi.iss0_reg_write = 1; sbi.iss0_rd = 5'd2;
    tick();
    check_out("clear_all", '0, '0, 1'b1);

    // Asynchronous reset mid-cycle with a load in flight.
    @(negedge clk); drive_idle();
    sbi.iss0_valid = 1; sbi.iss0_reg_write = 1; sbi.iss0_is_load = 1; sbi.iss0_rd = 5'd20;
    tick();
    check_out("pre_reset", bm(20), bm(20), 1'b1);
    #3 drive_idle(); rst_n = 1'b0;
    #1 check_out("async_reset", '0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    sbi.iss0_valid = 1; sbi.iss0_reg_write = 1; sbi.iss0_is_load = 1; sbi.iss0_rd = 5'd21;
    tick();
    check_out("first_edge", bm(21), bm(21), 1'b0);

    // Overflow: four writers to r11 saturate at three, so three writebacks drain it.
    @(negedge clk); drive_idle();
    sbi.iss0_valid = 1; sbi.iss0_reg_write = 1; sbi.iss0_rd = 5'd11;
    sbi.iss1_valid = 1; sbi.iss1_reg_write = 1; sbi.iss1_rd = 5'd11;
    tick();
    check_out("ovf_two", bm(11) | bm(21), bm(21), 1'b0);
    tick();
    check_out("ovf_sat", bm(11) | bm(21), bm(21), 1'b1);
    @(negedge clk); drive_idle();
    sbi.wb0_valid = 1; sbi.wb0_rd = 5'd11; sbi.wb1_valid = 1; sbi.wb1_rd = 5'd11;
    tick();
    check_out("ovf_drain2", bm(11) | bm(21), bm(21), 1'b1);
    @(negedge clk); sbi.wb1_valid = 0;
    tick();
    check_out("ovf_drain3", bm(21), bm(21), 1'b1);

    // Randomized run against the reference model, with periodic resets.
    @(negedge clk); drive_idle(); rst_n = 1'b0; model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 600 == 599) begin
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        #1 check_model("rand_reset");
        @(negedge clk) rst_n = 1'b1;
      end
      sbi.iss0_valid     = 1'($urandom_range(0, 1));
      sbi.iss0_reg_write = 1'($urandom_range(0, 3) != 0);
      sbi.iss0_is_load   = 1'($urandom_range(0, 1));
      sbi.iss0_rd        = 5'($urandom_range(0, 6));
      sbi.iss1_valid     = 1'($urandom_range(0, 1));
      sbi.iss1_reg_write = 1'($urandom_range(0, 3) != 0);
      sbi.iss1_is_load   = 1'($urandom_range(0, 1));
      sbi.iss1_rd        = 5'($urandom_range(0, 6));
      sbi.wb0_valid      = 1'($urandom_range(0, 1));
      sbi.wb0_rd         = 5'($urandom_range(0, 6));
      sbi.wb1_valid      = 1'($urandom_range(0, 2) == 0);
      sbi.wb1_rd         = 5'($urandom_range(0, 6));
      sbi.ld_done_valid  = 1'($urandom_range(0, 1));
      sbi.ld_done_rd     = 5'($urandom_range(0, 6));
      sbi.clear_all      = 1'($urandom_range(0, 63) == 0);
      tick();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
